// File: rtl/i2c_cfg_sequencer.sv
// Power-up configuration sequencer for the programmable-oscillator I2C port.
// After a settle delay it walks an external {reg, data} table and issues one
// single-byte write per entry to a byte-level I2C write engine, retrying
// failed attempts and spacing transactions with a bus-free gap.
module i2c_cfg_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h55,
    parameter int unsigned NUM_REGS       = 11,
    parameter int unsigned POWERUP_CYCLES = 91000000,
    parameter int unsigned GAP_CYCLES     = 200,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic        clk_40m,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    output logic        wr_req,
    input  logic        wr_ready,
    output logic [6:0]  wr_slave,
    output logic [7:0]  wr_reg,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    input  logic        wr_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [3:0]  cfg_index
);

    // Terminal counts are compared against "last value" so each phase
    // lasts exactly N cycles with the counter starting at zero.
    localparam logic [31:0] PWRUP_LAST   = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_INDEX   = 4'(NUM_REGS - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_reg;
    logic [31:0] cnt_reg;
    logic [3:0]  retry_reg;
    logic [3:0]  index_reg;

    logic attempt_ok;
    logic attempt_fail;
    logic last_entry;
    logic retry_exhausted;

    assign wr_slave  = SLAVE_ADDR;
    assign cfg_index = index_reg;

    // Outcome of the attempt in flight; wr_done takes priority over timeout.
    assign attempt_ok      = wr_done && !wr_nack;
    assign attempt_fail    = (wr_done && wr_nack) || (!wr_done && (cnt_reg == TIMEOUT_LAST));
    assign last_entry      = (index_reg == LAST_INDEX);
    assign retry_exhausted = ((retry_reg + 4'd1) == RETRY_LIMIT);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_40m) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            retry_reg <= '0;
            index_reg <= '0;
            tbl_addr  <= '0;
            wr_req    <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_reg   <= '0;
                    retry_reg <= '0;
                    index_reg <= '0;
                    cfg_done  <= 1'b0;
                    cfg_err   <= 1'b0;
                    cfg_busy  <= 1'b0;
                    if (start) begin
                        state_reg <= S_PWRUP;
                        cfg_busy  <= 1'b1;
                    end
                end
                S_PWRUP: begin
                    if (cnt_reg == PWRUP_LAST) begin
                        cnt_reg   <= '0;
                        tbl_addr  <= index_reg;
                        state_reg <= S_FETCH;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_FETCH: begin
                    // Table read is in flight; data is valid next cycle.
                    state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    wr_reg    <= tbl_data[15:8];
                    wr_data   <= tbl_data[7:0];
                    wr_req    <= 1'b1;
                    state_reg <= S_REQ;
                end
                S_REQ: begin
                    if (wr_ready) begin
                        wr_req    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (attempt_ok) begin
                        cnt_reg <= '0;
                        if (last_entry) begin
                            cfg_done  <= 1'b1;
                            cfg_busy  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            index_reg <= index_reg + 4'd1;
                            retry_reg <= '0;
                            state_reg <= S_GAP;
                        end
                    end else if (attempt_fail) begin
                        cnt_reg   <= '0;
                        retry_reg <= retry_reg + 4'd1;
                        if (retry_exhausted) begin
                            cfg_err   <= 1'b1;
                            cfg_busy  <= 1'b0;
                            state_reg <= S_ERROR;
                        end else begin
                            state_reg <= S_GAP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        // A non-zero retry count means the latched entry
                        // is re-sent without touching the table.
                        if (retry_reg == 4'd0) begin
                            tbl_addr  <= index_reg;
                            state_reg <= S_FETCH;
                        end else begin
                            wr_req    <= 1'b1;
                            state_reg <= S_REQ;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (!start) begin
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

Power-up configuration sequencer for the programmable-oscillator I2C port. It waits a power-up settle interval, then walks an external register table of {register address, data} pairs and issues one single-byte write per entry to a byte-level I2C write engine over a request/ready/done handshake. It retries NACKed or timed-out writes, enforces a bus-free gap between transactions, and raises a sticky `cfg_done` (gates DDS start) or `cfg_err`.

## Interface

Parameters:
- `SLAVE_ADDR`, 7'h55: 7-bit I2C slave address presented on `wr_slave`.
- `NUM_REGS`, 11: number of table entries to write (1..16).
- `POWERUP_CYCLES`, 91000000: clk_40m cycles spent in power-up wait.
- `GAP_CYCLES`, 200: idle cycles between end of one transaction and the next request.
- `MAX_RETRY`, 3: total attempts allowed per entry (1..15).
- `TIMEOUT_CYCLES`, 4000: cycles without `wr_done` before an attempt counts as failed.

Ports:
- `clk_40m` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; high enables the sequence.
- `tbl_addr` out 4: table index; reset 0.
- `tbl_data` in 16: {reg_addr[15:8], data[7:0]}; valid one cycle after `tbl_addr`.
- `wr_req` out 1: write request; reset 0.
- `wr_ready` in 1: engine accepts when `wr_req && wr_ready`.
- `wr_slave` out 7: constant `SLAVE_ADDR`.
- `wr_reg` out 8, `wr_data` out 8: latched entry; reset 0.
- `wr_done` in 1: one-cycle pulse at transaction end.
- `wr_nack` in 1: qualified by `wr_done`; 1 = any byte NACKed.
- `cfg_busy` out 1: state not IDLE/DONE/ERROR; reset 0.
- `cfg_done` out 1: all entries written; reset 0.
- `cfg_err` out 1: an entry exhausted its retries; reset 0.
- `cfg_index` out 4: current entry index; reset 0.

## Operation

- States: IDLE, PWRUP, FETCH, LOAD, REQ, WAIT, GAP, DONE, ERROR. All outputs are Moore/registered.
- IDLE: clear index, retry count and counters. When `start`=1, go to PWRUP.
- PWRUP: count `POWERUP_CYCLES` cycles, then go to FETCH.
- FETCH: `tbl_addr`=index; go to LOAD.
- LOAD: latch `tbl_data` into `wr_reg`/`wr_data`; go to REQ.
- REQ: `wr_req`=1; hold until `wr_ready`=1 in the same cycle; go to WAIT, and `wr_req` drops in the next cycle. Reset the timeout counter on entry to WAIT.
- WAIT: `wr_done`=1 with `wr_nack`=0 counts as success. `wr_done`=1 with `wr_nack`=1, or the timeout counter reaching `TIMEOUT_CYCLES`, counts as failure. If `wr_done` and timeout coincide, `wr_done` wins.
- Success: if index==`NUM_REGS`-1, go to DONE. Otherwise increment index, clear retry count, go to GAP, then FETCH.
- Failure: increment retry count. If the count reaches `MAX_RETRY`, go to ERROR. Otherwise go to GAP, then directly to REQ with the same latched data (no refetch).
- GAP: exactly `GAP_CYCLES` cycles.
- DONE: `cfg_done`=1. ERROR: `cfg_err`=1, `cfg_index` holds the failing entry. Both are sticky while `start`=1. `start`=0 returns to IDLE, clearing them.
- `start` falling in PWRUP..GAP is ignored; the sequence completes.
- `wr_done` outside WAIT is ignored.
- `rst` in any state: IDLE with all reset values in the next cycle, even mid-request. The engine is expected to share `rst`.
- Counters are 32-bit; the retry counter is 4-bit and the index is 4-bit. No wrap is possible within the parameter ranges.

## Timing

- `start` sampled high at edge t: PWRUP during cycles t+1..t+P, FETCH t+P+1, LOAD t+P+2, first `wr_req` high at t+P+3.
- Handshake accepted at cycle a: `wr_req` low from a+1.
- `wr_done` at cycle d, success, not last entry: GAP d+1..d+G, FETCH d+G+1, `wr_req` high at d+G+3 with the new data.
- `wr_done` at cycle d, retry: GAP d+1..d+G, `wr_req` high at d+G+1 with unchanged `wr_reg`/`wr_data`.
- `wr_done` at cycle d, success on last entry: `cfg_done` high at d+1, `cfg_busy` low at d+1.
- Timeout: failure declared `TIMEOUT_CYCLES` cycles after entering WAIT.

## Test plan

Bench parameters: P=10, G=4, NUM_REGS=3, MAX_RETRY=3, TIMEOUT=20. Table: {84,00},{00,33},{05,14}. Model engine: `wr_ready`=1 and `wr_done` 5 cycles after accept.

- Nominal: `start` high at t=0. Expect `wr_req` at cycle 13; three writes in order 84/00, 00/33, 05/14; `cfg_done`=1 one cycle after the third `wr_done`; `cfg_err`=0.
- NACK on entry 1, first attempt only: expect a second request for 00/33 at d+5, with no table fetch in between; then completion with `cfg_done`=1.
- NACK on every attempt of entry 2: expect exactly 3 requests for 05/14, then `cfg_err`=1 and `cfg_index`=2; no further requests.
- Engine never returns `wr_done`: expect failure at 20 cycles after each accept; after 3 attempts, `cfg_err`=1 and `cfg_index`=0.
- `wr_ready` held low 7 cycles: expect `wr_req` held high throughout with stable data, dropping the cycle after acceptance.
- `rst` asserted while in WAIT on entry 1: next cycle all outputs at reset values. Re-running with `start` high again performs the full sequence from entry 0, including the power-up wait.
